// File: rtl/b12_sequence_game.sv
// b12_sequence_game: "repeat the sequence" memory game controller.
// Each round a pseudo-random colour is appended to the stored sequence. The
// whole sequence is then replayed on the lights with a tone, and the player
// has to repeat it on the keys.
//
// Ports
//   clock    in   system clock, rising edge
//   reset    in   asynchronous active-high reset
//   start    in   synchronous request to begin a new game (wins over any state)
//   k[3:0]   in   one-hot player keys (0 red, 1 green, 2 yellow, 3 blue)
//   __obs    in   reserved observation input, no functional effect
//   nloss    out  high while in LOSS
//   nl[3:0]  out  lights
//   speaker  out  square-wave tone
//
// All outputs are registered from the current-state decode, so they appear
// one cycle after the state they belong to.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | after reset, dark and silent, waiting for start
// INIT     | clear sequence length and loss flag
// ADD      | append rnd to the sequence, restart replay at entry 0
// SHOW     | replay entry addr: SHOW_ON lit cycles, then SHOW_OFF dark
// WAIT_KEY | wait for the player's key for entry addr (with timeout)
// FEED     | echo the accepted key with its tone for FEED_CYCLES
// RELEASE  | wait for all keys up, then next entry / next round / win
// WIN      | all lights on, win tone, until start
// LOSS     | show the expected colour, loss tone, until start
module b12_sequence_game #(
  parameter int SEQ_LEN     = 32,
  parameter int SHOW_ON     = 8,
  parameter int SHOW_OFF    = 2,
  parameter int FEED_CYCLES = 4,
  parameter int KEY_TIMEOUT = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] k,
  input  logic       __obs,
  output logic       nloss,
  output logic [3:0] nl,
  output logic       speaker
);

  localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE, INIT, ADD, SHOW, WAIT_KEY, FEED, RELEASE, WIN, LOSS
  } state_t;

  state_t     state, state_nx;
  logic [5:0] length, length_nx;
  logic [5:0] addr, addr_nx;
  logic [7:0] timer, timer_nx;
  logic [7:0] timeout, timeout_nx;
  logic [3:0] key_q, key_nx;
  logic [1:0] rnd;
  logic [2:0] div;
  logic [1:0] mem [SEQ_LEN];

  logic       mem_we;
  logic       play;
  logic [2:0] tone;
  logic [3:0] nl_nx;
  logic       nloss_nx;
  logic [1:0] cur_col;
  logic [3:0] cur_hot;

  logic unused_obs;
  assign unused_obs = __obs;

  assign cur_col = mem[addr[IW-1:0]];
  assign cur_hot = 4'b0001 << cur_col;

  always_comb begin
    state_nx   = state;
    length_nx  = length;
    addr_nx    = addr;
    timer_nx   = timer;
    timeout_nx = timeout;
    key_nx     = key_q;
    mem_we     = 1'b0;
    play       = 1'b0;
    tone       = 3'd0;
    nl_nx      = 4'b0000;
    nloss_nx   = 1'b0;

    case (state)
      IDLE: ;
      INIT: begin
        length_nx = 6'd0;
        state_nx  = ADD;
      end
      ADD: begin
        mem_we    = 1'b1;
        length_nx = length + 6'd1;
        addr_nx   = 6'd0;
        timer_nx  = 8'd0;
        state_nx  = SHOW;
      end
      SHOW: begin
        if (timer < 8'(SHOW_ON)) begin
          nl_nx = cur_hot;
          play  = 1'b1;
          tone  = {1'b0, cur_col};
        end
        if (timer == 8'(SHOW_ON + SHOW_OFF - 1)) begin
          timer_nx = 8'd0;
          if (addr == length - 6'd1) begin
            addr_nx    = 6'd0;
            timeout_nx = 8'd0;
            state_nx   = WAIT_KEY;
          end else begin
            addr_nx = addr + 6'd1;
          end
        end else begin
          timer_nx = timer + 8'd1;
        end
      end
      WAIT_KEY: begin
        if (k == 4'b0000) begin
          // The KEY_TIMEOUT-th consecutive idle cycle is the losing one.
          if (timeout == 8'(KEY_TIMEOUT - 1)) state_nx = LOSS;
          else timeout_nx = timeout + 8'd1;
        end else if (k == cur_hot) begin
          key_nx   = k;
          timer_nx = 8'd0;
          state_nx = FEED;
        end else begin
          state_nx = LOSS;
        end
      end
      FEED: begin
        nl_nx = key_q;
        play  = 1'b1;
        tone  = {1'b0, cur_col};
        if (timer == 8'(FEED_CYCLES - 1)) state_nx = RELEASE;
        else timer_nx = timer + 8'd1;
      end
      RELEASE: begin
        if (k == 4'b0000) begin
          addr_nx = addr + 6'd1;
          if ((addr + 6'd1) < length) begin
            timeout_nx = 8'd0;
            state_nx   = WAIT_KEY;
          end else if (length == 6'(SEQ_LEN)) begin
            state_nx = WIN;
          end else begin
            state_nx = ADD;
          end
        end
      end
      WIN: begin
        nl_nx = 4'b1111;
        play  = 1'b1;
        tone  = 3'd4;
      end
      LOSS: begin
        nloss_nx = 1'b1;
        nl_nx    = cur_hot;
        play     = 1'b1;
        tone     = 3'd5;
      end
      default: state_nx = IDLE;
    endcase

    if (start) state_nx = INIT;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      length  <= 6'd0;
      addr    <= 6'd0;
      timer   <= 8'd0;
      timeout <= 8'd0;
      key_q   <= 4'b0000;
      rnd     <= 2'd0;
      div     <= 3'd0;
      speaker <= 1'b0;
      nl      <= 4'b0000;
      nloss   <= 1'b0;
    end else begin
      state   <= state_nx;
      length  <= length_nx;
      addr    <= addr_nx;
      timer   <= timer_nx;
      timeout <= timeout_nx;
      key_q   <= key_nx;
      rnd     <= rnd + 2'd1;
      nl      <= nl_nx;
      nloss   <= nloss_nx;
      // Tone divider: half-period is tone+1 cycles, silent and cleared when idle.
      if (!play) begin
        speaker <= 1'b0;
        div     <= 3'd0;
      end else if (div == tone) begin
        speaker <= ~speaker;
        div     <= 3'd0;
      end else begin
        div <= div + 3'd1;
      end
    end
  end

  // Sequence storage has no reset; entries are always written before being read.
  always_ff @(posedge clock) begin
    if (mem_we) mem[length[IW-1:0]] <= rnd;
  end

endmodule

// File: tb/tb_b12_sequence_game.sv
// Bench for b12_sequence_game. The reference is a game-level model: the
// sequence is a queue of colours, rnd is the number of edges since reset
// release mod 4, and each phase (replay, echo, win, loss) has its expected
// light/tone trace generated from the game rules. Outputs are registered, so
// every expected trace starts one cycle after the state it belongs to.
module tb_b12_sequence_game;
  localparam int SEQ_LEN = 3;
  localparam int SHOW_ON = 8;
  localparam int SHOW_OFF = 2;
  localparam int FEED_CYCLES = 4;
  localparam int KEY_TIMEOUT = 255;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] k;
  logic       obs;
  logic       nloss;
  logic [3:0] nl;
  logic       speaker;

  int n_pass = 0;
  int n_chk = 0;
  int ecnt = 0;
  int seq[$];

  always #5 clock = ~clock;

  b12_sequence_game #(
    .SEQ_LEN(SEQ_LEN), .SHOW_ON(SHOW_ON), .SHOW_OFF(SHOW_OFF),
    .FEED_CYCLES(FEED_CYCLES), .KEY_TIMEOUT(KEY_TIMEOUT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .k(k), .__obs(obs),
    .nloss(nloss), .nl(nl), .speaker(speaker)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, ecnt);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] enl, input logic enloss,
                         input logic espk);
    chk({tag, "_nl"}, {4'b0, nl}, {4'b0, enl});
    chk({tag, "_nloss"}, {7'b0, nloss}, {7'b0, enloss});
    chk({tag, "_spk"}, {7'b0, speaker}, {7'b0, espk});
  endtask

  // Speaker level on the n-th cycle (n >= 1) of a continuous tone.
  function automatic logic spk_at(input int n, input int tone);
    return ((n / (tone + 1)) % 2) == 1;
  endfunction

  function automatic logic [3:0] hot(input int c);
    return 4'(1 << c);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    ecnt++;
    obs = 1'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    k = 4'b0;
    #1;
    chk_out("reset", 4'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    ecnt = 0;
  endtask

  task automatic start_game();
    seq.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    chk_out("init", 4'b0, 1'b0, 1'b0);
  endtask

  task automatic add_round();
    step();
    seq.push_back((ecnt - 1) % 4);
    chk_out("add", 4'b0, 1'b0, 1'b0);
  endtask

  task automatic show_all();
    foreach (seq[i]) begin
      for (int n = 1; n <= SHOW_ON; n++) begin
        step();
        chk_out("show", hot(seq[i]), 1'b0, spk_at(n, seq[i]));
      end
      for (int n = 0; n < SHOW_OFF; n++) begin
        step();
        chk_out("gap", 4'b0, 1'b0, 1'b0);
      end
    end
  endtask

  // kind 0: wrong single colour, 1: several keys at once, 2: timeout.
  task automatic do_loss(input int kind, input int c, input int waited);
    logic [3:0] w;
    int b1, b2;
    if (kind == 2) begin
      for (int i = waited + 1; i <= KEY_TIMEOUT; i++) begin
        step();
        chk_out("timeout_wait", 4'b0, 1'b0, 1'b0);
      end
    end else begin
      if (kind == 0) begin
        w = hot((c + 1 + $urandom_range(0, 2)) % 4);
      end else begin
        b1 = $urandom_range(0, 3);
        b2 = (b1 + $urandom_range(1, 3)) % 4;
        w = hot(b1) | hot(b2) | 4'($urandom_range(0, 15));
      end
      k = w;
      step();
      chk_out("wrong_edge", 4'b0, 1'b0, 1'b0);
    end
    for (int n = 1; n <= 14; n++) begin
      k = 4'($urandom_range(0, 15));
      step();
      chk_out("loss", hot(c), 1'b1, spk_at(n, 5));
    end
    k = 4'b0;
  endtask

  // fail_round outside 1..SEQ_LEN plays a perfect game to WIN.
  task automatic play_game(input int fail_round, input int fail_pos, input int fail_kind);
    int c, d, h, j;
    start_game();
    for (int r = 1; r <= SEQ_LEN; r++) begin
      add_round();
      show_all();
      for (int p = 0; p < r; p++) begin
        c = seq[p];
        d = $urandom_range(0, 6);
        k = 4'b0;
        for (int i = 0; i < d; i++) begin
          step();
          chk_out("wait", 4'b0, 1'b0, 1'b0);
        end
        if (r == fail_round && p == fail_pos) begin
          do_loss(fail_kind, c, d);
          return;
        end
        h = $urandom_range(1, 7);
        k = hot(c);
        step();
        chk_out("press_edge", 4'b0, 1'b0, 1'b0);
        j = 1;
        while (j <= 20) begin
          k = (j < h) ? hot(c) : 4'b0;
          step();
          if (j <= FEED_CYCLES) begin
            chk_out("feed", hot(c), 1'b0, spk_at(j, c));
          end else begin
            chk_out("release", 4'b0, 1'b0, 1'b0);
            if (j >= h) break;
          end
          j++;
        end
        k = 4'b0;
      end
    end
    for (int n = 1; n <= 12; n++) begin
      step();
      chk_out("win", 4'b1111, 1'b0, spk_at(n, 4));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", ecnt);
    $fatal(1, "watchdog");
  end

  initial begin
    obs = 1'b0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step();
      chk_out("idle", 4'b0, 1'b0, 1'b0);
    end
    play_game(0, 0, 0);
    play_game(1, 0, 0);
    play_game(2, 1, 1);
    play_game(2, 0, 2);
    play_game(SEQ_LEN, SEQ_LEN - 1, 0);
    for (int g = 0; g < 6; g++) begin
      int fr;
      fr = $urandom_range(1, SEQ_LEN + 1);
      play_game(fr, $urandom_range(0, fr - 1), $urandom_range(0, 1));
    end
    play_game(0, 0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("post_reset", 4'b0, 1'b0, 1'b0);
    end
    play_game(0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/b12_sequence_game.md
Name: b12_sequence_game

Overview:
- Single-player "repeat the sequence" memory game controller.
- Each round, the block appends a pseudo-random colour (0..3) to a stored sequence and replays the whole sequence on four lights (nl) with a tone on speaker.
- The player then repeats the sequence on four one-hot keys (k).
- It drives a loss flag (nloss) and win/loss tones, and sits between the key/LED panel and a piezo speaker.

Parameters:
- SEQ_LEN, 32, sequence memory depth; a game is won when the sequence length reaches SEQ_LEN.
- SHOW_ON, 8, cycles each colour is lit and sounded during replay.
- SHOW_OFF, 2, dark/silent gap cycles after each replayed colour.
- FEED_CYCLES, 4, cycles a correct key is echoed on nl with its tone.
- KEY_TIMEOUT, 255, cycles allowed in WAIT_KEY before a loss.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  synchronous request to begin a new game.
- k  in  4  player keys; bit i = colour i (0 red, 1 green, 2 yellow, 3 blue).
- __obs  in  1  reserved observation/debug input; no functional effect.
- nloss  out  1  high while in LOSS.
- nl  out  4  lights, one-hot colour or pattern.
- speaker  out  1  square-wave tone output.

Behaviour:
- One clock, clock; reset is asynchronous and active-high.
- All outputs are registered.
- Reset values: state IDLE, nl 0000, nloss 0, speaker 0, length 0, rnd 0, all counters 0. Memory contents are don't-care.
- rnd: 2-bit free-running counter, increments every cycle (wraps 3 to 0), independent of state.
- Sound generator:
  - Inputs are play (1 bit) and tone (3 bits): 0..3 colour, 4 WIN, 5 LOSS.
  - play=0: speaker=0, divider=0.
  - play=1: divider counts up; when divider==tone, speaker toggles and divider clears. Half-period is tone+1 cycles.
- start=1 in any state takes priority: the next state is INIT.
- IDLE: nl=0, play=0. Waits for start.
- INIT: length=0, nloss=0, nl=0. Next state ADD.
- ADD (1 cycle): mem[length] <= rnd, length++, addr=0, timer=0. Next state SHOW.
- SHOW:
  - For timer 0..SHOW_ON-1: nl=onehot(mem[addr]), play=1, tone=mem[addr].
  - For the next SHOW_OFF cycles: nl=0, play=0.
  - Then addr++ and timer=0.
  - After the last entry (addr==length-1 finished): addr=0, timeout=0, next state WAIT_KEY.
- WAIT_KEY: nl=0, play=0.
  - k==0: timeout++; when timeout==KEY_TIMEOUT, go to LOSS.
  - k == onehot(mem[addr]): latch k, go to FEED.
  - Any other nonzero k (wrong colour or multiple bits): go to LOSS.
- FEED: nl=latched key, play=1, tone=colour, for FEED_CYCLES cycles. Then go to RELEASE.
- RELEASE: nl=0, play=0. Wait for k==0, then:
  - addr++.
  - If the new addr<length, go to WAIT_KEY (timeout=0).
  - Else if length==SEQ_LEN, go to WIN.
  - Else go to ADD.
- WIN: nl=1111, play=1, tone=4. Held until start.
- LOSS: nloss=1, nl=onehot(mem[addr]) (the expected colour), play=1, tone=5. Held until start.
- Reset mid-game: immediate return to the reset values above.
- length is 6 bits, so SEQ_LEN=32 is representable.

Test Plan:
- Reset asserted, then released with start=0 for 20 cycles -> nl=0000, nloss=0, speaker=0 throughout; state stays IDLE.
- start pulse of 1 cycle -> INIT, then ADD stores the current rnd (predictable from cycles since reset). nl shows that onehot for exactly 8 cycles with speaker toggling every rnd+1 cycles, then 2 dark cycles.
- After a 1-entry replay, press the correct one-hot key for 1 cycle then release -> nl echoes the key for 4 cycles. A new 2-entry replay follows, with entry 0 identical to before.
- In WAIT_KEY press a wrong key (or k=0011) -> next cycle nloss=1, nl=expected onehot, speaker half-period 6 cycles. start then clears nloss via INIT.
- In WAIT_KEY hold k=0 for 255 cycles -> LOSS entered, nloss=1.
- With SEQ_LEN overridden to 2, play both rounds correctly -> WIN: nl=1111, speaker half-period 5. Asserting reset mid-WIN returns all outputs to 0 immediately.
